// File: rtl/avalon_st_byte_packer_if.sv
// Avalon-ST style byte sink and packed-word source bundled for the byte packer.
// A beat transfers on a clock edge where valid && ready are both high; valid
// never depends on ready, and a held beat keeps its payload stable.
interface avalon_st_byte_packer_if #(
  parameter int BYTES = 4
);
  logic [7:0]         sink_data;
  logic               sink_valid;
  logic               sink_error;
  logic               sink_ready;
  logic [8*BYTES-1:0] source_data;
  logic               source_valid;
  logic               source_error;
  logic               source_ready;

  modport master (
    output sink_data, sink_valid, sink_error, source_ready,
    input  sink_ready, source_data, source_valid, source_error
  );

  modport slave (
    input  sink_data, sink_valid, sink_error, source_ready,
    output sink_ready, source_data, source_valid, source_error
  );
endinterface

// File: rtl/avalon_st_byte_packer.sv
// Packs BYTES consecutive 8-bit sink beats into one word (first byte in LSB),
// with a one-word output register and a saturating errored-word counter.
module avalon_st_byte_packer #(
  parameter int BYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  avalon_st_byte_packer_if.slave   st,
  output logic [7:0]               error_count
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  logic [IW-1:0]      idx_q, idx_d;
  logic [8*BYTES-1:0] acc_q, acc_d;
  logic               err_acc_q, err_acc_d;
  logic [8*BYTES-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_err_q, out_err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               last_w;
  logic               sink_ready_w;
  logic               sink_xfer;
  logic               src_xfer;
  logic [8*BYTES-1:0] word_w;
  logic               word_err_w;

  always_comb begin
    last_w       = (idx_q == LAST);
    // Only the completing beat needs room in the output register.
    sink_ready_w = !last_w || !out_valid_q || st.source_ready;
    sink_xfer    = st.sink_valid && sink_ready_w;
    src_xfer     = out_valid_q && st.source_ready;

    word_w = acc_q;
    for (int k = 0; k < BYTES; k++) begin
      if (idx_q == IW'(k)) word_w[8*k +: 8] = st.sink_data;
    end
    word_err_w = err_acc_q | st.sink_error;

    idx_d       = idx_q;
    acc_d       = acc_q;
    err_acc_d   = err_acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;

    if (sink_xfer) begin
      if (last_w) begin
        idx_d       = '0;
        acc_d       = '0;
        err_acc_d   = 1'b0;
        out_valid_d = 1'b1;
        out_data_d  = word_w;
        out_err_d   = word_err_w;
      end else begin
        idx_d     = idx_q + IW'(1);
        acc_d     = word_w;
        err_acc_d = word_err_w;
      end
    end

    // A load in the same cycle as a drain keeps the register full.
    if (src_xfer && !(sink_xfer && last_w)) out_valid_d = 1'b0;

    if (src_xfer && out_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      err_acc_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      err_acc_q   <= err_acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign st.sink_ready   = sink_ready_w;
  assign st.source_data  = out_data_q;
  assign st.source_valid = out_valid_q;
  assign st.source_error = out_err_q;
  assign error_count     = err_cnt_q;
endmodule

// File: doc/avalon_st_byte_packer.md
AVALON_ST_BYTE_PACKER -- requirements
Module: avalon_st_byte_packer

Interface
REQ-001 Parameter BYTES, default 4: number of 8-bit sink beats packed per output word; legal range 2..8.
REQ-002 Port clk: input, 1 bit; the single clock; all state changes on its rising edge.
REQ-003 Port reset_n: input, 1 bit; asynchronous reset, active-low.
REQ-004 Port sink_data: input, 8 bits; byte carried by the current sink beat.
REQ-005 Port sink_valid: input, 1 bit; sink beat present.
REQ-006 Port sink_error: input, 1 bit; current sink beat is corrupt.
REQ-007 Port sink_ready: output, 1 bit; block accepts the sink beat this cycle.
REQ-008 Port source_data: output, 8*BYTES bits; packed word.
REQ-009 Port source_valid: output, 1 bit; packed word present.
REQ-010 Port source_error: output, 1 bit; at least one byte of the word was received with sink_error=1.
REQ-011 Port source_ready: input, 1 bit; downstream accepts the word.
REQ-012 Port error_count: output, 8 bits; number of words emitted with source_error=1, saturating.

Function
REQ-013 A sink beat SHALL transfer when sink_valid && sink_ready; a source word SHALL transfer when source_valid && source_ready.
REQ-014 Byte lane order: the k-th accepted byte of a word (k=0..BYTES-1) lands in source_data[8k+7:8k] (first byte in LSB).
REQ-015 Byte counter idx: range 0..BYTES-1; +1 per sink transfer; wraps to 0 on the transfer that completes a word.
REQ-016 Partial bytes are held in an accumulator register; word error flag = OR of sink_error over the word's beats.
REQ-017 On the completing beat (idx==BYTES-1), the full word and its error flag are loaded into the output register and source_valid is set on the next cycle (latency 1 clk from last-byte transfer to source_valid).
REQ-018 sink_ready = (idx != BYTES-1) || !source_valid || source_ready; combinational; no dependency on sink_valid.
REQ-019 Non-completing beats are always accepted, including while the output register is stalled.
REQ-020 source_valid, source_data, source_error are registered outputs; they SHALL hold stable while source_valid && !source_ready.
REQ-021 Output register load and drain in the same cycle: the new word replaces the drained one; source_valid stays 1.
REQ-022 Drain without load: source_valid clears on the next cycle.
REQ-023 Sustained throughput with source_ready=1: one word per BYTES clk, no bubbles.
REQ-024 error_count increments by 1 on each source transfer with source_error=1; holds at 255 (no wrap).
REQ-025 source_ready is ignored while source_valid=0; sink_error is ignored on non-transfer cycles.

Reset
REQ-026 reset_n=0 SHALL immediately clear idx, accumulator, word error flag, source_valid, source_data (all zero), source_error, error_count.
REQ-027 Reset mid-word discards the partial word; the first beat after release is lane 0.
REQ-028 Reset while a word is stalled on the output discards the word; no transfer is emitted after release.
REQ-029 sink_ready SHALL be 1 during and immediately after reset (idx=0).

Verification
REQ-030 Beats 0x01,0x02,0x03,0x04 back-to-back, source_ready=1 -> one transfer source_data=0x04030201, source_error=0, 1 clk after 4th beat.
REQ-031 Continuous stream 0x01..0x10, source_ready=1 -> words 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D on every 4th clk, sink_ready stays 1.
REQ-032 source_ready=0 with word 0x04030201 pending, then 8 more beats 0x05..0x0C -> beats 0x05..0x07 accepted, sink_ready=0 while 0x08 offered; data held stable; after source_ready=1 -> 0x04030201, 0x08070605, 0x0C0B0A09 in order, nothing lost or duplicated.
REQ-033 sink_error=1 on byte 0x06 only of stream 0x05..0x08 -> word 0x08070605 with source_error=1, error_count=1; next clean word source_error=0.
REQ-034 Send 0x11,0x22, assert reset_n=0 for 2 clk, then 0x01..0x04 -> only 0x04030201 emitted; error_count=0.
REQ-035 300 consecutive words with one errored byte each -> error_count reaches 255 and holds.
